// File: rtl/npc_pkg.sv
// Shared NPC definitions: instruction encodings and halt controller states.
package npc_pkg;

  // EBREAK is the only encoding that halts the core; ECALL is kept here so
  // decode and the difftest harness compare against the same constant.
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_DRAIN  = 2'd1,
    HS_REPORT = 2'd2,
    HS_HALT   = 2'd3
  } halt_state_e;

endpackage

// File: rtl/ebreak_halt_ctrl_if.sv
// Retire-port / halt-report bundle between the retire logic (master) and
// the EBREAK halt controller (slave).
interface ebreak_halt_ctrl_if #(
  parameter int XLEN = 32
);

  logic            retire_valid;
  logic [31:0]     retire_inst;
  logic [XLEN-1:0] retire_pc;
  logic [XLEN-1:0] a0_data;
  logic            pipe_busy;

  logic            halt_req;
  logic            is_ebreak;
  logic            halted;
  logic [XLEN-1:0] exit_code;
  logic [XLEN-1:0] halt_pc;
  logic            drain_timeout;

  modport master (
    output retire_valid, retire_inst, retire_pc, a0_data, pipe_busy,
    input  halt_req, is_ebreak, halted, exit_code, halt_pc, drain_timeout
  );

  modport slave (
    input  retire_valid, retire_inst, retire_pc, a0_data, pipe_busy,
    output halt_req, is_ebreak, halted, exit_code, halt_pc, drain_timeout
  );

endinterface

// File: rtl/ebreak_halt_ctrl.sv
// EBREAK halt controller: freezes the front end on EBREAK retirement,
// drains in-flight work (bounded by DRAIN_MAX cycles), then reports the
// halt once to the DPI ebreak stage and parks until reset.
module ebreak_halt_ctrl
  import npc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  ebreak_halt_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);

  localparam logic [1:0] RUN    = HS_RUN;
  localparam logic [1:0] DRAIN  = HS_DRAIN;
  localparam logic [1:0] REPORT = HS_REPORT;
  localparam logic [1:0] HALT   = HS_HALT;

  logic [1:0]      state;
  logic [CNT_W-1:0] drain_cnt;
  logic            halt_req_q;
  logic            is_ebreak_q;
  logic            halted_q;
  logic            drain_timeout_q;
  logic [XLEN-1:0] exit_code_q;
  logic [XLEN-1:0] halt_pc_q;
  logic            ebreak_hit;

  // Only an exact EBREAK encoding on a valid retirement starts a halt.
  assign ebreak_hit = bus.retire_valid && (bus.retire_inst == EBREAK_INST);

  // Halt sequencer: every output is a register updated on the state transition
  // that makes it true, so nothing downstream sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state and datapath registers here are all reset; halt_pc and
    // exit_code must read 0 after reset, so they are not left uninitialised.
    if (!rst_n) begin
      state           <= RUN;
      drain_cnt       <= '0;
      halt_req_q      <= 1'b0;
      is_ebreak_q     <= 1'b0;
      halted_q        <= 1'b0;
      drain_timeout_q <= 1'b0;
      exit_code_q     <= '0;
      halt_pc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch sees the pre-edge state.
      case (state)
        RUN: begin
          if (ebreak_hit) begin
            halt_pc_q   <= bus.retire_pc;
            exit_code_q <= bus.a0_data;
            drain_cnt   <= '0;
            halt_req_q  <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          // A clean drain takes priority over a timeout in the same cycle.
          if (!bus.pipe_busy) begin
            is_ebreak_q <= 1'b1;
            state       <= REPORT;
          end else if (drain_cnt == CNT_LAST) begin
            drain_timeout_q <= 1'b1;
            is_ebreak_q     <= 1'b1;
            state           <= REPORT;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          is_ebreak_q <= 1'b0;
          halted_q    <= 1'b1;
          state       <= HALT;
        end
        HALT: begin
          // Absorbing: only reset leaves this state.
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.halt_req      = halt_req_q;
  assign bus.is_ebreak     = is_ebreak_q;
  assign bus.halted        = halted_q;
  assign bus.drain_timeout = drain_timeout_q;
  assign bus.exit_code     = exit_code_q;
  assign bus.halt_pc       = halt_pc_q;

endmodule
